// File: rtl/watch_alarm_core.sv
// 24-hour watch core: seconds divider, hh:mm:ss counter, N_ALARM alarm channels and a ring FSM.
// Define WATCH_12H_EN to add the registered 12-hour outputs HOUR12 and PM.
module watch_alarm_core #(
   parameter int  TICK_DIV = 10000,
   parameter int  N_ALARM  = 2,
   parameter int  RING_SEC = 30,
   localparam int IDXW     = (N_ALARM > 1) ? $clog2(N_ALARM) : 1
) (
   input  logic            CLK,
   input  logic            RESET,
   input  logic            SET_EN,
   input  logic [4:0]      SET_HOUR,
   input  logic [5:0]      SET_MIN,
   input  logic [5:0]      SET_SEC,
   input  logic            ALM_WE,
   input  logic [IDXW-1:0] ALM_IDX,
   input  logic [4:0]      ALM_HOUR,
   input  logic [5:0]      ALM_MIN,
   input  logic            ALM_ENA,
   input  logic            ALM_ACK,
   output logic [4:0]      HOUR,
   output logic [5:0]      MIN,
   output logic [5:0]      SEC,
   output logic            TICK,
   output logic            RING,
   output logic [IDXW-1:0] RING_IDX,
   output logic            SET_ERR
`ifdef WATCH_12H_EN
   ,
   output logic [3:0]      HOUR12,
   output logic            PM
`endif
);

   localparam int              DIVW      = $clog2(TICK_DIV);
   localparam logic [DIVW-1:0] DIV_LAST  = DIVW'(TICK_DIV - 1);
   localparam logic [7:0]      RING_LAST = 8'(RING_SEC - 1);
   localparam logic [IDXW:0]   IDX_LIM   = (IDXW + 1)'(N_ALARM);

   typedef enum logic [0:0] {
      ST_IDLE    = 1'b0,
      ST_RINGING = 1'b1
   } ring_state_t;

   logic [DIVW-1:0] div_r, div_nxt_s;
   logic [4:0]      hour_r, hour_nxt_s;
   logic [5:0]      min_r, min_nxt_s;
   logic [5:0]      sec_r, sec_nxt_s;
   logic            tick_r, tick_nxt_s;
   logic            set_ok_s, alm_ok_s;
   logic            set_err_r, set_err_nxt_s;

   logic [4:0]      alm_hour_r [N_ALARM];
   logic [5:0]      alm_min_r  [N_ALARM];
   logic            alm_ena_r  [N_ALARM];

   logic [N_ALARM-1:0] hit_s;
   logic               match_s;
   logic [IDXW-1:0]    match_idx_s;

   ring_state_t     state_r, state_nxt_s;
   logic [7:0]      ring_cnt_r, ring_cnt_nxt_s;
   logic [IDXW-1:0] ring_idx_r, ring_idx_nxt_s;
   logic            ring_r;

`ifdef WATCH_12H_EN
   logic [3:0]      hour12_r;
   logic            pm_r;

   function automatic logic [3:0] to_hour12(input logic [4:0] h);
      logic [4:0] t;
      if (h == 5'd0) begin
         t = 5'd12;
      end else if (h > 5'd12) begin
         t = h - 5'd12;
      end else begin
         t = h;
      end
      return t[3:0];
   endfunction
`endif

   // Write validation and next time-of-day; a valid load overrides a coincident second advance
   always_comb begin
      set_ok_s = SET_EN && (SET_HOUR < 5'd24) && (SET_MIN < 6'd60) && (SET_SEC < 6'd60);
      alm_ok_s = ALM_WE && ({1'b0, ALM_IDX} < IDX_LIM) && (ALM_HOUR < 5'd24) && (ALM_MIN < 6'd60);
      set_err_nxt_s = (SET_EN && !set_ok_s) || (ALM_WE && !alm_ok_s);
      div_nxt_s  = div_r;
      hour_nxt_s = hour_r;
      min_nxt_s  = min_r;
      sec_nxt_s  = sec_r;
      tick_nxt_s = 1'b0;
      if (set_ok_s) begin
         div_nxt_s  = '0;
         hour_nxt_s = SET_HOUR;
         min_nxt_s  = SET_MIN;
         sec_nxt_s  = SET_SEC;
      end else if (div_r == DIV_LAST) begin
         div_nxt_s  = '0;
         tick_nxt_s = 1'b1;
         if (sec_r == 6'd59) begin
            sec_nxt_s = 6'd0;
            if (min_r == 6'd59) begin
               min_nxt_s = 6'd0;
               if (hour_r == 5'd23) begin
                  hour_nxt_s = 5'd0;
               end else begin
                  hour_nxt_s = hour_r + 5'd1;
               end
            end else begin
               min_nxt_s = min_r + 6'd1;
            end
         end else begin
            sec_nxt_s = sec_r + 6'd1;
         end
      end else begin
         div_nxt_s = div_r + DIVW'(1);
      end
   end

   // Time-of-day, divider, tick and error pulse registers
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         div_r     <= '0;
         hour_r    <= 5'd0;
         min_r     <= 6'd0;
         sec_r     <= 6'd0;
         tick_r    <= 1'b0;
         set_err_r <= 1'b0;
      end else begin
         div_r     <= div_nxt_s;
         hour_r    <= hour_nxt_s;
         min_r     <= min_nxt_s;
         sec_r     <= sec_nxt_s;
         tick_r    <= tick_nxt_s;
         set_err_r <= set_err_nxt_s;
      end
   end

   // Alarm channel storage
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         for (int i = 0; i < N_ALARM; i++) begin
            alm_hour_r[i] <= 5'd0;
            alm_min_r[i]  <= 6'd0;
            alm_ena_r[i]  <= 1'b0;
         end
      end else begin
         for (int i = 0; i < N_ALARM; i++) begin
            if (alm_ok_s && (ALM_IDX == IDXW'(i))) begin
               alm_hour_r[i] <= ALM_HOUR;
               alm_min_r[i]  <= ALM_MIN;
               alm_ena_r[i]  <= ALM_ENA;
            end
         end
      end
   end

   // Matches exist only in the tick cycle, so a direct time load can never ring
   always_comb begin
      hit_s = '0;
      for (int i = 0; i < N_ALARM; i++) begin
         hit_s[i] = tick_r && (sec_r == 6'd0) && alm_ena_r[i]
                    && (alm_hour_r[i] == hour_r) && (alm_min_r[i] == min_r);
      end
      match_s     = |hit_s;
      match_idx_s = '0;
      for (int i = N_ALARM - 1; i >= 0; i--) begin
         match_idx_s = hit_s[i] ? IDXW'(i) : match_idx_s;
      end
   end

   // Ring FSM next state: a new match restarts the ring and beats a coincident ack
   always_comb begin
      state_nxt_s    = state_r;
      ring_cnt_nxt_s = ring_cnt_r;
      ring_idx_nxt_s = ring_idx_r;
      case (state_r)
         ST_IDLE: begin
            if (match_s) begin
               state_nxt_s    = ST_RINGING;
               ring_cnt_nxt_s = 8'd0;
               ring_idx_nxt_s = match_idx_s;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_RINGING: begin
            if (match_s) begin
               ring_cnt_nxt_s = 8'd0;
               ring_idx_nxt_s = match_idx_s;
            end else if (ALM_ACK) begin
               state_nxt_s = ST_IDLE;
            end else if (tick_r) begin
               if (ring_cnt_r == RING_LAST) begin
                  state_nxt_s = ST_IDLE;
               end else begin
                  ring_cnt_nxt_s = ring_cnt_r + 8'd1;
               end
            end else begin
               state_nxt_s = ST_RINGING;
            end
         end
         default: begin
            state_nxt_s    = ST_IDLE;
            ring_cnt_nxt_s = 8'd0;
         end
      endcase
   end

   // Ring FSM state and registered ring outputs
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_r    <= ST_IDLE;
         ring_cnt_r <= 8'd0;
         ring_idx_r <= '0;
         ring_r     <= 1'b0;
      end else begin
         state_r    <= state_nxt_s;
         ring_cnt_r <= ring_cnt_nxt_s;
         ring_idx_r <= ring_idx_nxt_s;
         ring_r     <= (state_nxt_s == ST_RINGING);
      end
   end

`ifdef WATCH_12H_EN
   // 12-hour view registered from the same next-hour value as HOUR
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         hour12_r <= 4'd12;
         pm_r     <= 1'b0;
      end else begin
         hour12_r <= to_hour12(hour_nxt_s);
         pm_r     <= (hour_nxt_s >= 5'd12);
      end
   end

   assign HOUR12 = hour12_r;
   assign PM     = pm_r;
`endif

   assign HOUR     = hour_r;
   assign MIN      = min_r;
   assign SEC      = sec_r;
   assign TICK     = tick_r;
   assign RING     = ring_r;
   assign RING_IDX = ring_idx_r;
   assign SET_ERR  = set_err_r;

endmodule

// File: tb/tb_watch_alarm_core.sv
// Randomized bench for watch_alarm_core against a seconds-of-day reference model.
// Honours WATCH_12H_EN when the design is built with it.
`timescale 1ns/1ps
module tb_watch_alarm_core;
   localparam int TICK_DIV = 4;
   localparam int N_ALARM  = 2;
   localparam int RING_SEC = 3;
   localparam int IDXW     = 1;

   logic            CLK = 1'b0;
   logic            RESET;
   logic            SET_EN;
   logic [4:0]      SET_HOUR;
   logic [5:0]      SET_MIN, SET_SEC;
   logic            ALM_WE;
   logic [IDXW-1:0] ALM_IDX;
   logic [4:0]      ALM_HOUR;
   logic [5:0]      ALM_MIN;
   logic            ALM_ENA, ALM_ACK;
   logic [4:0]      HOUR;
   logic [5:0]      MIN, SEC;
   logic            TICK, RING, SET_ERR;
   logic [IDXW-1:0] RING_IDX;
`ifdef WATCH_12H_EN
   logic [3:0]      HOUR12;
   logic            PM;
`endif

   int checks   = 0;
   int failures = 0;

   // reference model: time as seconds of day, divider as a cycle count
   int m_div, m_tod, m_tick, m_ring, m_ring_idx, m_ring_ticks, m_set_err;
   int m_ah [N_ALARM];
   int m_am [N_ALARM];
   int m_ae [N_ALARM];

   always #5 CLK = ~CLK;

   watch_alarm_core #(.TICK_DIV(TICK_DIV), .N_ALARM(N_ALARM), .RING_SEC(RING_SEC)) dut (
      .CLK(CLK), .RESET(RESET),
      .SET_EN(SET_EN), .SET_HOUR(SET_HOUR), .SET_MIN(SET_MIN), .SET_SEC(SET_SEC),
      .ALM_WE(ALM_WE), .ALM_IDX(ALM_IDX), .ALM_HOUR(ALM_HOUR), .ALM_MIN(ALM_MIN),
      .ALM_ENA(ALM_ENA), .ALM_ACK(ALM_ACK),
      .HOUR(HOUR), .MIN(MIN), .SEC(SEC), .TICK(TICK), .RING(RING),
      .RING_IDX(RING_IDX), .SET_ERR(SET_ERR)
`ifdef WATCH_12H_EN
      , .HOUR12(HOUR12), .PM(PM)
`endif
   );

   task automatic check_eq(input string tag, input int obs, input int exp);
      checks++;
      if (obs != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

`ifdef WATCH_12H_EN
   function automatic int exp_h12(input int h);
      if (h == 0) return 12;
      else if (h > 12) return h - 12;
      else return h;
   endfunction
`endif

   task automatic model_reset();
      m_div = 0; m_tod = 0; m_tick = 0; m_ring = 0;
      m_ring_idx = 0; m_ring_ticks = 0; m_set_err = 0;
      for (int i = 0; i < N_ALARM; i++) begin
         m_ah[i] = 0; m_am[i] = 0; m_ae[i] = 0;
      end
   endtask

   // one clock edge of the model, using the inputs held across that edge
   task automatic model_step();
      int match, midx;
      bit set_ok, alm_ok;
      match = 0; midx = 0;
      if (m_tick == 1 && (m_tod % 60) == 0) begin
         for (int i = N_ALARM - 1; i >= 0; i--) begin
            if (m_ae[i] == 1 && (m_ah[i] * 3600 + m_am[i] * 60) == m_tod) begin
               match = 1; midx = i;
            end
         end
      end
      if (match == 1) begin
         m_ring = 1; m_ring_idx = midx; m_ring_ticks = 0;
      end else if (m_ring == 1 && ALM_ACK) begin
         m_ring = 0;
      end else if (m_ring == 1 && m_tick == 1) begin
         m_ring_ticks++;
         if (m_ring_ticks >= RING_SEC) m_ring = 0;
      end
      set_ok = SET_EN && int'(SET_HOUR) < 24 && int'(SET_MIN) < 60 && int'(SET_SEC) < 60;
      alm_ok = ALM_WE && int'(ALM_IDX) < N_ALARM && int'(ALM_HOUR) < 24 && int'(ALM_MIN) < 60;
      if (set_ok) begin
         m_tod = int'(SET_HOUR) * 3600 + int'(SET_MIN) * 60 + int'(SET_SEC);
         m_div = 0; m_tick = 0;
      end else if (m_div == TICK_DIV - 1) begin
         m_div = 0; m_tod = (m_tod + 1) % 86400; m_tick = 1;
      end else begin
         m_div++; m_tick = 0;
      end
      if (alm_ok) begin
         m_ah[int'(ALM_IDX)] = int'(ALM_HOUR);
         m_am[int'(ALM_IDX)] = int'(ALM_MIN);
         m_ae[int'(ALM_IDX)] = int'(ALM_ENA);
      end
      m_set_err = ((SET_EN && !set_ok) || (ALM_WE && !alm_ok)) ? 1 : 0;
   endtask

   task automatic compare_outputs();
      check_eq("hour", int'(HOUR), m_tod / 3600);
      check_eq("min", int'(MIN), (m_tod / 60) % 60);
      check_eq("sec", int'(SEC), m_tod % 60);
      check_eq("tick", int'(TICK), m_tick);
      check_eq("ring", int'(RING), m_ring);
      check_eq("ring_idx", int'(RING_IDX), m_ring_idx);
      check_eq("set_err", int'(SET_ERR), m_set_err);
`ifdef WATCH_12H_EN
      check_eq("hour12", int'(HOUR12), exp_h12(m_tod / 3600));
      check_eq("pm", int'(PM), (m_tod / 3600 >= 12) ? 1 : 0);
`endif
   endtask

   task automatic step();
      @(posedge CLK);
      model_step();
      #1;
      compare_outputs();
   endtask

   task automatic idle_inputs();
      SET_EN = 1'b0; SET_HOUR = 5'd0; SET_MIN = 6'd0; SET_SEC = 6'd0;
      ALM_WE = 1'b0; ALM_IDX = '0; ALM_HOUR = 5'd0; ALM_MIN = 6'd0;
      ALM_ENA = 1'b0; ALM_ACK = 1'b0;
   endtask

   task automatic set_time(input int h, input int m, input int s);
      SET_EN = 1'b1; SET_HOUR = 5'(h); SET_MIN = 6'(m); SET_SEC = 6'(s);
      step();
      SET_EN = 1'b0;
   endtask

   task automatic write_alarm(input int idx, input int h, input int m, input int ena);
      ALM_WE = 1'b1; ALM_IDX = IDXW'(idx); ALM_HOUR = 5'(h); ALM_MIN = 6'(m); ALM_ENA = 1'(ena);
      step();
      ALM_WE = 1'b0;
   endtask

   task automatic wait_tick(input int bound);
      for (int k = 0; k < bound; k++) begin
         step();
         if (TICK) break;
      end
      check_eq("tick_seen", int'(TICK), 1);
   endtask

   task automatic wait_ring(input int bound);
      for (int k = 0; k < bound; k++) begin
         step();
         if (RING) break;
      end
      check_eq("ring_seen", int'(RING), 1);
   endtask

   task automatic check_all_zero(input string tag);
      check_eq({tag, "_hour"}, int'(HOUR), 0);
      check_eq({tag, "_min"}, int'(MIN), 0);
      check_eq({tag, "_sec"}, int'(SEC), 0);
      check_eq({tag, "_tick"}, int'(TICK), 0);
      check_eq({tag, "_ring"}, int'(RING), 0);
      check_eq({tag, "_ring_idx"}, int'(RING_IDX), 0);
      check_eq({tag, "_set_err"}, int'(SET_ERR), 0);
   endtask

   initial begin
      int cnt;
      int first;
      RESET = 1'b0;
      idle_inputs();
      model_reset();
      #1 RESET = 1'b1;
      #1 check_all_zero("reset");
      @(posedge CLK);
      @(posedge CLK);
      #3 RESET = 1'b0;

      // roll over midnight: two ticks in 8 cycles, never hour 24
      set_time(23, 59, 58);
      cnt = 0;
      for (int k = 0; k < 8; k++) begin
         step();
         if (TICK) cnt++;
         check_eq("hour_lt_24", (int'(HOUR) < 24) ? 1 : 0, 1);
      end
      check_eq("midnight_ticks", cnt, 2);
      check_eq("midnight_tod", int'(HOUR) * 3600 + int'(MIN) * 60 + int'(SEC), 0);

      // rejected load, then a load that lands on a tick
      set_time(24, 0, 0);
      check_eq("bad_set_err", int'(SET_ERR), 1);
      step();
      check_eq("bad_set_err_drop", int'(SET_ERR), 0);
      for (int k = 0; k < 8; k++) begin
         if (m_div == TICK_DIV - 1) break;
         step();
      end
      check_eq("div_aligned", m_div, TICK_DIV - 1);
      set_time(12, 34, 56);
      check_eq("load_tick_suppressed", int'(TICK), 0);
      check_eq("load_sec", int'(SEC), 56);
      write_alarm(0, 24, 0, 1);
      check_eq("bad_alarm_err", int'(SET_ERR), 1);

      // two channels match: lowest index rings one cycle after the tick
      write_alarm(0, 7, 0, 1);
      write_alarm(1, 7, 0, 1);
      set_time(6, 59, 59);
      wait_tick(8);
      check_eq("ring_on_tick", int'(RING), 0);
      step();
      check_eq("ring_after_tick", int'(RING), 1);
      check_eq("ring_idx_lowest", int'(RING_IDX), 0);

      // disabling the ringing channel keeps it ringing; drops after RING_SEC ticks
      write_alarm(0, 7, 0, 0);
      cnt = (TICK && RING) ? 1 : 0;
      for (int k = 0; k < 40; k++) begin
         step();
         if (!RING) break;
         if (TICK) cnt++;
      end
      check_eq("ring_timeout_ticks", cnt, RING_SEC);
      check_eq("ring_timeout_off", int'(RING), 0);

      // acknowledge mid-ring
      write_alarm(1, 7, 0, 0);
      write_alarm(0, 7, 0, 1);
      set_time(6, 59, 59);
      wait_ring(10);
      step();
      ALM_ACK = 1'b1;
      step();
      ALM_ACK = 1'b0;
      check_eq("ack_ring_off", int'(RING), 0);

      // a direct load onto the alarm time never rings
      write_alarm(0, 8, 0, 1);
      set_time(8, 0, 0);
      for (int k = 0; k < 8; k++) step();
      check_eq("load_no_ring", int'(RING), 0);

      // reset while ringing
      set_time(7, 59, 59);
      wait_ring(10);
      #2 RESET = 1'b1;
      #1 check_all_zero("mid_ring_reset");
      model_reset();
      @(posedge CLK);
      #1 compare_outputs();
      #2 RESET = 1'b0;
      first = 0;
      for (int k = 1; k <= 20; k++) begin
         step();
         if (TICK) begin
            first = k;
            break;
         end
      end
      check_eq("first_tick_after_reset", first, TICK_DIV);

`ifdef WATCH_12H_EN
      set_time(0, 0, 0);
      check_eq("h12_0", int'(HOUR12), 12);
      check_eq("pm_0", int'(PM), 0);
      set_time(12, 0, 0);
      check_eq("h12_12", int'(HOUR12), 12);
      check_eq("pm_12", int'(PM), 1);
      set_time(13, 0, 0);
      check_eq("h12_13", int'(HOUR12), 1);
      check_eq("pm_13", int'(PM), 1);
`endif

      // randomized traffic
      for (int c = 0; c < 4000; c++) begin
         int r;
         int a;
         idle_inputs();
         r = int'($urandom_range(0, 99));
         if (r < 2) begin
            SET_EN = 1'b1;
            a = int'($urandom_range(0, N_ALARM - 1));
            if ($urandom_range(0, 1) == 1) begin
               SET_HOUR = 5'(m_ah[a]);
               SET_MIN  = 6'((m_am[a] + 59) % 60);
               SET_SEC  = 6'($urandom_range(55, 59));
            end else begin
               SET_HOUR = 5'($urandom_range(0, 25));
               SET_MIN  = 6'($urandom_range(0, 61));
               SET_SEC  = 6'($urandom_range(50, 61));
            end
         end
         r = int'($urandom_range(0, 99));
         if (r < 3) begin
            ALM_WE   = 1'b1;
            ALM_IDX  = IDXW'($urandom_range(0, N_ALARM - 1));
            ALM_HOUR = ($urandom_range(0, 3) != 0) ? 5'(m_tod / 3600) : 5'($urandom_range(0, 25));
            ALM_MIN  = ($urandom_range(0, 3) != 0) ? 6'(((m_tod / 60) + 1) % 60) : 6'($urandom_range(0, 61));
            ALM_ENA  = ($urandom_range(0, 3) != 0);
         end
         ALM_ACK = ($urandom_range(0, 39) == 0);
         step();
      end
      idle_inputs();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
